// File: rtl/abro_input_conditioner.sv
// Conditions the raw A, B and R push-buttons for the ABRO machine.
// Each channel has a 2-flop synchronizer, a debounce FSM and a registered rise pulse.
module abro_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    input  logic r_raw,
    output logic A,
    output logic B,
    output logic a_rise,
    output logic b_rise,
    output logic r_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } deb_state_t;

    logic [2:0] raw_vec;

    assign raw_vec = {r_raw, b_raw, a_raw};

    // Channel 0 = A, 1 = B, 2 = R; the channels share nothing but the clock and reset.
    genvar g;
    for (g = 0; g < 3; g++) begin : g_ch
        logic            sync_q;
        logic            s;
        deb_state_t      state_q;
        deb_state_t      state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic            level_q;
        logic            level_d;
        logic            rise_q;
        logic            rise_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= 1'b0;
                s      <= 1'b0;
            end else begin
                sync_q <= raw_vec[g];
                s      <= sync_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
            end
        end

        // An opposite sample in either WAIT state drops straight back, so the count never wraps.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    assign A       = g_ch[0].level_q;
    assign B       = g_ch[1].level_q;
    assign a_rise  = g_ch[0].rise_q;
    assign b_rise  = g_ch[1].rise_q;
    assign r_pulse = g_ch[2].rise_q;

endmodule

// File: doc/abro_input_conditioner.md
# abro_input_conditioner

Front-end stage that conditions three raw, asynchronous, bouncy push-button inputs (A, B, R) for the ABRO state machine. Each channel is synchronized, debounced by a per-channel state machine, and presented downstream as a clean level plus a one-cycle rising-edge pulse. `A` and `B` drive the ABRO machine's A/B inputs; `r_pulse` is the request that the top level turns into the ABRO restart.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive equal synchronized samples required to accept a new level; legal range 2..65535.
- `clk`  input  1  single clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `a_raw`  input  1  raw button A, asynchronous to `clk`.
- `b_raw`  input  1  raw button B, asynchronous to `clk`.
- `r_raw`  input  1  raw button R, asynchronous to `clk`.
- `A`  output  1  debounced level of A.
- `B`  output  1  debounced level of B.
- `a_rise`  output  1  one-cycle pulse on a 0->1 transition of `A`.
- `b_rise`  output  1  one-cycle pulse on a 0->1 transition of `B`.
- `r_pulse`  output  1  one-cycle pulse on an accepted 0->1 transition of R.

## Operation
- Three identical, fully independent channels. No priority and no interaction between channels.
- Synchronizer: a 2-flop chain per channel. `s` is the second flop's output.
- Debounce FSM per channel, with counter `cnt` of width ceil(log2(DEBOUNCE_CYCLES)) + 1:
  - STABLE_LO (level = 0): if `s` = 1, go to WAIT_HI with `cnt` = 1.
  - WAIT_HI (level = 0):
    - if `s` = 0, go to STABLE_LO with `cnt` = 0 (glitch rejected, no pulse);
    - else if `cnt` = DEBOUNCE_CYCLES-1, go to STABLE_HI, set level = 1 and assert the rise pulse;
    - else `cnt` += 1.
  - STABLE_HI (level = 1): if `s` = 0, go to WAIT_LO with `cnt` = 1.
  - WAIT_LO (level = 1):
    - if `s` = 1, go to STABLE_HI with `cnt` = 0;
    - else if `cnt` = DEBOUNCE_CYCLES-1, go to STABLE_LO and set level = 0 (no pulse on fall);
    - else `cnt` += 1.
- Level and pulse outputs are registered. A pulse is high for exactly one cycle per accepted rise. A level held high indefinitely produces only one pulse.
- The R channel exposes only `r_pulse`; its level is internal.

## Timing
- Reset values: all synchronizer flops 0, every FSM in STABLE_LO, `cnt` = 0, and `A`, `B`, `a_rise`, `b_rise`, `r_pulse` all 0.
- Latency: let edge 1 be the first rising edge that samples the new raw value. The level changes, and the rise pulse asserts, at edge DEBOUNCE_CYCLES+2, provided raw is held through edge DEBOUNCE_CYCLES. The pulse deasserts at the next edge.
- With DEBOUNCE_CYCLES = 4: raw high sampled at edges 1–4 gives `A` = 1 and `a_rise` = 1 after edge 6, and `a_rise` = 0 after edge 7.
- A raw pulse sampled at fewer than DEBOUNCE_CYCLES consecutive edges never changes the output. Any opposite sample restarts the count.
- Simultaneous rises on different channels pulse in the same cycle when their raw timing is identical.
- Raw held high through reset release: the channel debounces normally and emits one rise pulse DEBOUNCE_CYCLES+2 edges after release.
- Reset asserted mid-WAIT_HI: the count is aborted, outputs go to 0 immediately (asynchronously), and no pulse is produced.
- Reset asserted in the pulse cycle: the pulse clears immediately.
- The counter never exceeds DEBOUNCE_CYCLES-1 and does not wrap.

## Test plan
- Clean press, DEBOUNCE_CYCLES = 4: `a_raw` 0->1 before edge 1 and held -> `A` = 1 and `a_rise` = 1 after edge 6, `a_rise` = 0 after edge 7, no further pulses over 20 cycles.
- Glitch rejection: `b_raw` high for exactly 3 sampled edges, then low -> `B` and `b_rise` stay 0 throughout.
- Bounce then settle: `a_raw` pattern 1,0,1,1,0,1 then held high -> exactly one `a_rise`, occurring 6 edges after the final 0->1 sample. Release with the same bounce pattern -> `A` falls once and no pulse is produced.
- Simultaneous inputs: `a_raw` and `b_raw` rise together and hold -> `a_rise` and `b_rise` both pulse on the same cycle; `r_pulse` stays 0.
- Reset mid-debounce: `r_raw` high, `rst` asserted after edge 4 for 2 cycles, `r_raw` still high -> `r_pulse` = 0 during reset, then exactly one `r_pulse` 6 edges after reset release.
- Parameter sweep at DEBOUNCE_CYCLES = 2 and 16: clean press -> level rises after edge 4 and after edge 18 respectively, each with a single-cycle pulse.
